// File: rtl/sonar_scheduler_pkg.sv
// sonar_scheduler_pkg: shared state codes, BCD width and round-robin sensor pick.
package sonar_scheduler_pkg;
   localparam int BCD_W = 12;
   typedef enum logic [3:0] {
      OCIOSO    = 4'h0,
      SELECIONA = 4'h1,
      DISPARA   = 4'h2,
      AGUARDA   = 4'h3,
      REGISTRA  = 4'h4,
      ESPERA    = 4'h5,
      ABORTA    = 4'hE
   } estado_t;
   // First enabled sensor after ultimo, wrapping; ultimo itself is checked last.
   function automatic logic [1:0] proximo(input logic [3:0] req, input logic [1:0] ultimo);
      logic [1:0] s;
      proximo = ultimo;
      for (int k = 4; k >= 1; k--) begin
         s = ultimo + 2'(k);
         if (req[s]) proximo = s;
      end
   endfunction
endpackage

// File: rtl/sonar_scheduler_contador.sv
// contador_m: saturating up-counter with synchronous clear; fim flags the terminal count M-1.
module contador_m #(
   parameter int M = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic zera,
   input  logic conta,
   output logic fim
);
   localparam int W = $clog2(M);
   logic [W-1:0] q;
   always_ff @(posedge clock or posedge reset)
      if (reset) q <= '0;
      else if (zera) q <= '0;
      else if (conta && !fim) q <= q + W'(1);
   assign fim = q == W'(M - 1);
endmodule

// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin trigger scheduler for up to four ultrasonic sensors
// sharing one measurement interface, with fixed pulse spacing and timeout recovery.
module sonar_scheduler
   import sonar_scheduler_pkg::*;
#(
   parameter int INTERVALO = 3000000,
   parameter int TIMEOUT   = 2500000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ligar,
   input  logic [3:0]       req,
   input  logic             pronto_if,
   input  logic [BCD_W-1:0] medida_if,
   output logic             medir_if,
   output logic             reset_if,
   output logic [1:0]       sel,
   output logic [BCD_W-1:0] dist_out,
   output logic [1:0]       dist_id,
   output logic             dist_valid,
   output logic             timeout,
   output logic [3:0]       db_estado
);
   estado_t estado;
   logic [1:0] ultimo;
   logic fim_int, fim_to;
   // Both counters restart the cycle after DISPARA. The interval terminal count
   // is shortened by the SELECIONA+DISPARA cycles and the timeout one by the
   // AGUARDA->ABORTA step, so pulses land exactly INTERVALO/TIMEOUT cycles apart.
   contador_m #(.M(INTERVALO - 2)) u_intervalo (
      .clock(clock), .reset(reset), .zera(estado == DISPARA), .conta(1'b1), .fim(fim_int)
   );
   contador_m #(.M(TIMEOUT - 1)) u_timeout (
      .clock(clock), .reset(reset), .zera(estado == DISPARA), .conta(estado == AGUARDA), .fim(fim_to)
   );
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         estado   <= OCIOSO;
         ultimo   <= 2'd3;
         sel      <= '0;
         dist_out <= '0;
         dist_id  <= '0;
      end else
         case (estado)
            OCIOSO:
               if (ligar && req != '0) estado <= SELECIONA;
            SELECIONA:
               if (req == '0) estado <= OCIOSO;
               else begin
                  sel    <= proximo(req, ultimo);
                  estado <= DISPARA;
               end
            DISPARA: begin
               ultimo <= sel;
               estado <= AGUARDA;
            end
            AGUARDA:
               if (pronto_if) begin
                  dist_out <= medida_if;
                  dist_id  <= sel;
                  estado   <= REGISTRA;
               end else if (fim_to) estado <= ABORTA;
            REGISTRA, ABORTA:
               estado <= ESPERA;
            ESPERA:
               if (!ligar) estado <= OCIOSO;
               else if (fim_int) estado <= SELECIONA;
            default:
               estado <= OCIOSO;
         endcase
   assign medir_if   = estado == DISPARA;
   assign dist_valid = estado == REGISTRA;
   assign reset_if   = estado == ABORTA;
   assign timeout    = estado == ABORTA;
   assign db_estado  = estado;
endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: scoreboard bench with a small interface model answering each medir_if.
module tb_sonar_scheduler;
   import sonar_scheduler_pkg::*;
   logic clock = 0, reset = 1, ligar = 0, pronto_if = 0;
   logic [3:0] req = '0;
   logic [11:0] medida_if = 12'hFFF;
   logic medir_if, reset_if, dist_valid, timeout;
   logic [1:0] sel, dist_id;
   logic [11:0] dist_out;
   logic [3:0] db_estado;
   sonar_scheduler #(.INTERVALO(20), .TIMEOUT(10)) dut (
      .clock(clock), .reset(reset), .ligar(ligar), .req(req), .pronto_if(pronto_if),
      .medida_if(medida_if), .medir_if(medir_if), .reset_if(reset_if), .sel(sel),
      .dist_out(dist_out), .dist_id(dist_id), .dist_valid(dist_valid), .timeout(timeout),
      .db_estado(db_estado)
   );
   always #5 clock = ~clock;
   typedef struct {bit to; logic [1:0] id; logic [11:0] d; int c;} exp_t;
   exp_t sb[$];
   int total = 0, bad = 0, cyc = 0, lat = 5, due = 0, last_medir = -1, start_cyc = 0, n_medir = 0;
   bit pend = 0, first = 0, hold3 = 0;
   logic [1:0] last_id = 2'd3;
   logic [11:0] val = '0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
      end
   endtask
   function automatic logic [1:0] exp_sel(input logic [3:0] r, input logic [1:0] l);
      int s;
      for (int k = 1; k <= 4; k++) begin
         s = (int'(l) + k) % 4;
         if (r[s]) return 2'(s);
      end
      return l;
   endfunction
   always @(posedge clock) cyc <= cyc + 1;
   always @(negedge clock) begin : mon
      exp_t e;
      logic [1:0] es;
      pronto_if = 0;
      medida_if = 12'hFFF;
      if (hold3) chk("sel_hold", sel, 3);
      if (medir_if) begin
         es = exp_sel(req, last_id);
         chk("sel", sel, es);
         last_id = es;
         if (first) chk("start_lat", cyc - start_cyc, 2);
         first = 0;
         if (last_medir >= 0) chk("gap", cyc - last_medir, 20);
         last_medir = cyc;
         n_medir++;
         val = {4'($urandom % 10), 4'($urandom % 10), 4'($urandom % 10)};
         e.to = !(lat > 0 && lat < 10);
         e.id = es;
         e.d = val;
         e.c = cyc + (e.to ? 10 : lat + 1);
         sb.push_back(e);
         if (lat > 0) begin
            pend = 1;
            due = cyc + lat;
         end
      end
      if (pend && cyc == due) begin
         pronto_if = 1;
         medida_if = val;
         pend = 0;
      end
      if (dist_valid || timeout) begin
         if (sb.size() == 0) chk("unexpected", 1, 0);
         else begin
            e = sb.pop_front();
            chk("kind", timeout, e.to);
            chk("dv_xor_to", dist_valid ^ timeout, 1);
            chk("when", cyc, e.c);
            chk("rst_if", reset_if, timeout);
            if (!e.to) begin
               chk("dist", dist_out, e.d);
               chk("id", dist_id, e.id);
            end
         end
      end
   end
   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clock);
         #2;
      end
   endtask
   task automatic wait_medir(input int t);
      int k = 0;
      while (n_medir < t && k < 200) begin
         step();
         k++;
      end
      chk("wait_medir", n_medir >= t, 1);
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_st"}, db_estado, 0);
      chk({tag, "_pulses"}, {medir_if, reset_if, dist_valid, timeout}, 0);
      chk({tag, "_dist"}, dist_out, 0);
      chk({tag, "_id"}, dist_id, 0);
      chk({tag, "_sel"}, sel, 0);
   endtask
   initial begin
      step(2);
      chk_zero("rst");
      reset = 0;
      step(3);
      chk("idle", db_estado, 0);
      req = 4'b0101;
      ligar = 1;
      first = 1;
      start_cyc = cyc;
      wait_medir(4);
      lat = -1;
      wait_medir(6);
      lat = 9;
      wait_medir(8);
      lat = 5;
      step();
      ligar = 0;
      step(60);
      chk("drop_no_medir", n_medir, 8);
      chk("drop_idle", db_estado, 0);
      chk("drop_sb", sb.size(), 0);
      lat = -1;
      ligar = 1;
      last_medir = -1;
      first = 1;
      start_cyc = cyc;
      wait_medir(9);
      step();
      chk("pre_rst_st", db_estado, 3);
      reset = 1;
      #1;
      chk_zero("mid_rst");
      sb.delete();
      last_id = 2'd3;
      step();
      lat = 5;
      reset = 0;
      first = 1;
      start_cyc = cyc;
      last_medir = -1;
      wait_medir(10);
      chk("after_rst_sel", sel, 0);
      req = 4'b1000;
      wait_medir(11);
      hold3 = 1;
      wait_medir(12);
      step();
      req = 4'b0000;
      step(40);
      chk("req0_no_medir", n_medir, 12);
      chk("req0_idle", db_estado, 0);
      hold3 = 0;
      step(5);
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sonar_scheduler.md
SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

Interface
REQ-001 Parameter INTERVALO, default 3000000, minimum clock cycles between consecutive medir_if pulses (60 ms at 50 MHz).
REQ-002 Parameter TIMEOUT, default 2500000, maximum cycles in AGUARDA before a measurement is abandoned.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ligar  input  1  level; high enables continuous round-robin scanning.
REQ-006 req  input  4  per-sensor enable mask; bit i enables sensor i.
REQ-007 pronto_if  input  1  one-cycle completion pulse from the ultrasonic interface.
REQ-008 medida_if  input  12  3-digit BCD distance from the interface, valid while pronto_if is high.
REQ-009 medir_if  output  1  one-cycle start pulse to the interface.
REQ-010 reset_if  output  1  one-cycle pulse that aborts the interface after a timeout.
REQ-011 sel  output  2  sensor index that drives the trigger/echo mux.
REQ-012 dist_out  output  12  last captured BCD distance.
REQ-013 dist_id  output  2  sensor index of dist_out.
REQ-014 dist_valid  output  1  one-cycle pulse when dist_out/dist_id update.
REQ-015 timeout  output  1  one-cycle pulse when a measurement is abandoned.
REQ-016 db_estado  output  4  debug state code.

Function
REQ-017 FSM states and codes: OCIOSO=0, SELECIONA=1, DISPARA=2, AGUARDA=3, REGISTRA=4, ESPERA=5, ABORTA=E.
REQ-018 OCIOSO: go to SELECIONA when ligar=1 and req!=0; otherwise remain in OCIOSO.
REQ-019 SELECIONA: load sel with the first set bit of req, scanning ultimo+1, ultimo+2, ultimo+3, ultimo+4 (mod 4); go to DISPARA; if req=0, go to OCIOSO with sel unchanged.
REQ-020 DISPARA: assert medir_if for exactly one cycle, clear the interval and timeout counters, set ultimo=sel, go to AGUARDA.
REQ-021 AGUARDA: on pronto_if=1, go to REGISTRA; if the timeout counter reaches TIMEOUT-1, go to ABORTA.
REQ-022 If pronto_if and timeout expiry occur in the same cycle, pronto_if wins.
REQ-023 REGISTRA: capture medida_if into dist_out and sel into dist_id, pulse dist_valid for one cycle, go to ESPERA.
REQ-024 ABORTA: pulse reset_if and timeout for one cycle each, leave dist_out unchanged, go to ESPERA.
REQ-025 ESPERA: when the interval counter reaches INTERVALO-1, go to SELECIONA if ligar=1, else go to OCIOSO.
REQ-026 ESPERA also goes to OCIOSO immediately if ligar=0.
REQ-027 ligar falling during SELECIONA, DISPARA or AGUARDA does not abort; the current measurement completes or times out first.
REQ-028 Latency: ligar sampled high in OCIOSO produces medir_if exactly 2 cycles later.
REQ-029 The interval counter runs freely from DISPARA, so the spacing between medir_if pulses is exactly INTERVALO cycles when ligar and req stay constant and INTERVALO exceeds the measurement time.
REQ-030 pronto_if outside AGUARDA is ignored.
REQ-031 req changes take effect at the next SELECIONA only.
REQ-032 Counters are sized with $clog2 of their parameter, saturate, and never wrap.
REQ-033 All outputs are registered or decoded from the state only; no output depends combinationally on any input.

Reset
REQ-034 Reset forces state OCIOSO, ultimo=3 (first served sensor is 0), sel=0, dist_out=0, dist_id=0, and all pulse outputs 0.
REQ-035 Reset forces both counters to 0 and db_estado=0.
REQ-036 Reset mid-measurement abandons it with no dist_valid or timeout pulse.

Structure
REQ-037 A shared package holds the state encodings, the db_estado codes, and the BCD width (12).
REQ-038 A parameterised sub-module contador_m (up-counter with zera, conta and fim outputs) is instantiated twice: once for the interval counter and once for the timeout counter.

Verification (INTERVALO=20, TIMEOUT=10)
REQ-039 req=0101, ligar=1, the interface model returns pronto 5 cycles after medir -> medir_if every 20 cycles, sel sequence 0,2,0,2, and dist_id matches sel.
REQ-040 The interface model never returns pronto -> timeout and reset_if pulse 10 cycles after medir_if, dist_valid stays 0, and the next sensor is selected.
REQ-041 pronto_if arrives on the same cycle as timeout expiry -> dist_valid=1 and timeout=0.
REQ-042 ligar drops during AGUARDA -> the measurement completes, then the FSM enters OCIOSO with no further medir_if.
REQ-043 reset asserted in AGUARDA -> all outputs are 0 immediately and the next start selects sensor 0.
REQ-044 req=1000 -> sel stays 3 for every cycle; req switched to 0000 -> the FSM returns to OCIOSO at the next SELECIONA.
